enc_link_decoder: RTL and testbench

Receive-side stage directly downstream of the 8-to-3 line encoder. It takes the 3-bit encoded link word plus an even-parity bit and checks parity. Good words are buffered in a small FIFO and presented downstream as both a one-hot 8-bit line vector and the raw 3-bit code, under a valid/ready handshake. Bad-parity words are dropped and counted.

---
 rtl/enc_link_pkg.sv | 17 +
 rtl/enc_link_fifo.sv | 64 ++++++
 rtl/enc_link_decoder.sv | 75 +++++++
 tb/tb_enc_link_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_link_pkg.sv
// Shared constants and helpers for the encoded-link receive path.
package enc_link_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

  // Expand a 3-bit line code back into its one-hot line vector.
  function automatic logic [LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return LINES'(1) << code;
  endfunction

  // Even parity: the code bits plus the parity bit must XOR to zero.
  function automatic logic parity_ok(input logic [CODE_W-1:0] code, input logic par);
    return ~^{code, par};
  endfunction

endpackage

// File: rtl/enc_link_fifo.sv
// Generic synchronous FIFO. The occupancy count is the only full/empty
// indicator, so the pointers can wrap freely modulo DEPTH (a power of 2).
// The head is read combinationally: no fall-through, a pushed word shows
// up only after the edge that wrote it.
module enc_link_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LEVEL_W'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO is refused even when a pop happens in the same
  // cycle; the caller sees the refusal through full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; stale contents are never
  // observable because level gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/enc_link_decoder.sv
// Receive stage after the 8-to-3 line encoder: checks even parity, buffers
// good codes, presents the head as raw code and one-hot line vector, and
// drops/counts bad-parity words.
module enc_link_decoder
  import enc_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_parity,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LINES-1:0]       out_onehot,
  output logic [CODE_W-1:0]      out_code,
  input  logic                   err_clr,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   err_pulse,
  output logic [$clog2(DEPTH):0] level
);

  logic              full;
  logic              empty;
  logic              accept;
  logic              good;
  logic              bad;
  logic [CODE_W-1:0] head;

  // Ready depends only on registered occupancy, never on out_ready, so a
  // full FIFO stays closed for one cycle even while it is being popped.
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign good     = accept && parity_ok(in_code, in_parity);
  assign bad      = accept && !parity_ok(in_code, in_parity);

  enc_link_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (good),
    .data  (in_code),
    .pop   (out_valid && out_ready),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Head outputs are masked while empty so unreset storage never leaks out.
  assign out_valid  = !empty;
  assign out_code   = out_valid ? head : '0;
  assign out_onehot = out_valid ? code_to_onehot(head) : '0;

  // Error strobe and saturating counter; a clear wins over an increment but
  // does not suppress the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (err_clr)
        err_cnt <= '0;
      else if (bad && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_enc_link_decoder.sv
// Self-checking bench for enc_link_decoder: a reference queue plus error
// model is updated at each clock edge; outputs are sampled on the falling edge.
module tb_enc_link_decoder;

  localparam int DEPTH   = 4;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_parity = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_onehot;
  logic [2:0] out_code;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;
  logic       err_pulse;
  logic [2:0] level;

  enc_link_decoder #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_parity  (in_parity),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
    .err_pulse  (err_pulse),
    .level      (level)
  );

  always #5 clk = ~clk;

  int         passed = 0;
  int         total  = 0;
  logic [2:0] sb[$];
  int         m_level = 0;
  int         m_err   = 0;
  logic       m_pulse = 1'b0;

  // One clock cycle: called on a falling edge, drives inputs, records the
  // head presented before the rising edge, updates the model, returns on
  // the next falling edge.
  task automatic drive(input logic v, input logic [2:0] code, input logic par,
                       input logic rdy, input logic clr,
                       output logic popped, output logic [2:0] obs,
                       output logic [2:0] exp);
    logic acc;
    logic good;
    in_valid  = v;
    in_code   = code;
    in_parity = par;
    out_ready = rdy;
    err_clr   = clr;
    #1;
    popped = !rst && (m_level != 0) && rdy;
    obs    = out_code;
    exp    = '0;
    acc    = !rst && v && (m_level != DEPTH);
    good   = ((code[0] ^ code[1] ^ code[2]) == par);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_err   = 0;
      m_pulse = 1'b0;
      popped  = 1'b0;
    end else begin
      if (popped) exp = sb.pop_front();
      if (acc && good) sb.push_back(code);
      m_pulse = acc && !good;
      if (clr) m_err = 0;
      else if (acc && !good && m_err < ERR_MAX) m_err++;
    end
    m_level = sb.size();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic test_reset();
    logic p; logic [2:0] o, e;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during: got %b want 0", in_ready); else passed++;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, p, o, e);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, p, o, e);
    rst = 1'b0;
    #1;
    total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_onehot !== 8'h00) $display("FAIL reset_onehot: got %h want 00", out_onehot); else passed++;
    total++; if (out_code !== 3'd0) $display("FAIL reset_out_code: got %0d want 0", out_code); else passed++;
    total++; if (err_cnt !== 8'd0 || err_pulse !== 1'b0) $display("FAIL reset_err: got cnt=%0d pulse=%b want 0/0", err_cnt, err_pulse); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_single();
    logic p; logic [2:0] o, e;
    drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, p, o, e);
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_code !== 3'd5) $display("FAIL single_code: got %0d want 5", out_code); else passed++;
    total++; if (out_onehot !== 8'b0010_0000) $display("FAIL single_onehot: got %b want 00100000", out_onehot); else passed++;
    total++; if (level !== 3'd1) $display("FAIL single_level: got %0d want 1", level); else passed++;
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, p, o, e);
    if (p) begin
      total++; if (o !== e) $display("FAIL single_pop: got %0d want %0d", o, e); else passed++;
    end
    total++; if (level !== 3'd0 || out_onehot !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL single_drained: got level=%0d onehot=%h valid=%b want 0/00/0", level, out_onehot, out_valid);
    else passed++;
  endtask

  task automatic test_parity_err();
    logic p; logic [2:0] o, e;
    int pulses;
    drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, p, o, e);
    total++; if (level !== 3'd0) $display("FAIL perr_no_push: got level %0d want 0", level); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL perr_pulse_hi: got %b want 1", err_pulse); else passed++;
    total++; if (err_cnt !== 8'd1) $display("FAIL perr_cnt1: got %0d want 1", err_cnt); else passed++;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, p, o, e);
    total++; if (err_pulse !== 1'b0) $display("FAIL perr_pulse_lo: got %b want 0", err_pulse); else passed++;
    pulses = 0;
    for (int i = 0; i < 299; i++) begin
      drive(1'b1, 3'(i), ~^3'(i), 1'b0, 1'b0, p, o, e);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 299) $display("FAIL perr_pulse_count: got %0d want 299", pulses); else passed++;
    total++; if (err_cnt !== 8'd255 || m_err != 255) $display("FAIL perr_saturate: got %0d want 255", err_cnt); else passed++;
    drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, p, o, e);
    total++; if (err_cnt !== 8'd0) $display("FAIL perr_clr_priority: got %0d want 0", err_cnt); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL perr_clr_pulse: got %b want 1", err_pulse); else passed++;
    total++; if (level !== 3'(m_level)) $display("FAIL perr_level: got %0d want %0d", level, m_level); else passed++;
  endtask

  task automatic test_fill();
    logic p; logic [2:0] o, e;
    logic [7:0] oh [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), ^3'(i), 1'b0, 1'b0, p, o, e);
    total++; if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passed++;
    drive(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, p, o, e);
    total++; if (level !== 3'd4) $display("FAIL fill_fifth_ignored: got %0d want 4", level); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_onehot !== oh[i]) $display("FAIL fill_onehot%0d: got %h want %h", i, out_onehot, oh[i]); else passed++;
      drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, p, o, e);
      total++; if (!p || o !== e || o !== 3'(i)) $display("FAIL fill_order%0d: got %0d want %0d", i, o, i); else passed++;
    end
  endtask

  task automatic test_full_pop();
    logic p; logic [2:0] o, e;
    logic [2:0] codes [4] = '{3'd6, 3'd7, 3'd5, 3'd4};
    for (int i = 0; i < 4; i++) drive(1'b1, codes[i], ^codes[i], 1'b0, 1'b0, p, o, e);
    drive(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, p, o, e);
    total++; if (!p || o !== 3'd6 || o !== e) $display("FAIL fullpop_head: got %0d want 6", o); else passed++;
    total++; if (level !== 3'd3) $display("FAIL fullpop_level: got %0d want 3", level); else passed++;
    drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, p, o, e);
    total++; if (level !== 3'd4) $display("FAIL fullpop_next_push: got %0d want 4", level); else passed++;
    while (m_level != 0) begin
      drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, p, o, e);
      if (p) begin
        total++; if (o !== e) $display("FAIL fullpop_drain: got %0d want %0d", o, e); else passed++;
      end
    end
  endtask

  task automatic test_stream();
    logic p; logic [2:0] o, e;
    int n = 0, npop = 0, cyc = 0;
    logic will;
    logic rdy;
    while ((n < 24 || m_level != 0) && cyc < 400) begin
      will = (n < 24) && (m_level != DEPTH);
      rdy  = (n >= 24) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(n < 24, 3'(n % 8), ^3'(n % 8), rdy, 1'b0, p, o, e);
      if (will) n++;
      if (p) begin
        total++; if (o !== e || o !== 3'(npop % 8)) $display("FAIL stream_word%0d: got %0d want %0d", npop, o, npop % 8); else passed++;
        npop++;
      end
      cyc++;
    end
    total++; if (npop != 24 || level !== 3'd0) $display("FAIL stream_count: got %0d words level %0d want 24 words level 0", npop, level); else passed++;
  endtask

  task automatic test_reset_mid();
    logic p; logic [2:0] o, e;
    for (int i = 0; i < 3; i++) drive(1'b1, 3'(i + 3), ^3'(i + 3), 1'b0, 1'b0, p, o, e);
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, p, o, e);
    total++; if (level !== 3'd3 || err_cnt !== 8'd1) $display("FAIL rstmid_pre: got level=%0d err=%0d want 3/1", level, err_cnt); else passed++;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready_during: got %b want 0", in_ready); else passed++;
    drive(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, p, o, e);
    rst = 1'b0;
    #1;
    total++; if (level !== 3'd0 || out_valid !== 1'b0) $display("FAIL rstmid_fifo: got level=%0d valid=%b want 0/0", level, out_valid); else passed++;
    total++; if (err_cnt !== 8'd0) $display("FAIL rstmid_err: got %0d want 0", err_cnt); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready_after: got %b want 1", in_ready); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_parity_err();
    test_fill();
    test_full_pop();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
